// File: rtl/subbytes_seq_if.sv
// Handshake bundle for subbytes_seq: input word channel, result channel and the
// sticky self-check error flag. The master drives words in and accepts results.
interface subbytes_seq_if #(
  parameter int unsigned NUM_BYTES = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_inv;
  logic [8*NUM_BYTES-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*NUM_BYTES-1:0] out_data;
  logic                   err;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, err
  );
endinterface

// File: rtl/subbytes_seq.sv
// Sequential AES SubBytes / InvSubBytes stage. LANES S-box lookups per cycle,
// walked over NUM_BYTES/LANES beats, most-significant chunk first.
// The S-box tables are built as combinational GF(2^8) inverse + affine logic,
// which is bit-identical to the FIPS-197 forward and inverse tables.
// Optional macro SUBBYTES_SELFCHECK_EN: each lane re-maps its result through the
// opposite table and raises a sticky err on any disagreement with the source.
module subbytes_seq #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned LANES     = 4
) (
  input logic           clk,
  input logic           rst,
  subbytes_seq_if.slave bus
);

  localparam int unsigned BEATS  = NUM_BYTES / LANES;
  localparam int unsigned DataW  = 8 * NUM_BYTES;
  localparam int unsigned ChunkW = 8 * LANES;
  localparam int unsigned CntW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if (LANES == 0 || (NUM_BYTES % LANES) != 0) begin : g_bad_lanes
    $error("subbytes_seq: LANES must divide NUM_BYTES");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  src_q, src_d;
  logic              inv_q, inv_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [ChunkW-1:0] chunk;
  logic [ChunkW-1:0] lane_sub;

  // Select the source chunk addressed by the beat counter.
  always_comb begin
    chunk = '0;
    for (int unsigned c = 0; c < BEATS; c++) begin
      if (cnt_q == CntW'(c)) chunk = src_q[DataW-1-c*ChunkW -: ChunkW];
    end
  end

  // Per-lane table lookup, forward or inverse by the captured mode.
  always_comb begin
    logic [7:0] b;
    b        = 8'h00;
    lane_sub = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      b = chunk[ChunkW-1-8*l -: 8];
      lane_sub[ChunkW-1-8*l -: 8] = inv_q ? inv_sbox(b) : fwd_sbox(b);
    end
  end

`ifdef SUBBYTES_SELFCHECK_EN
  logic err_q, err_d;
  logic chk_fail;

  // Map each result back through the opposite table; it must return the source byte.
  always_comb begin
    logic [7:0] back;
    back     = 8'h00;
    chk_fail = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      back = inv_q ? fwd_sbox(lane_sub[ChunkW-1-8*l -: 8])
                   : inv_sbox(lane_sub[ChunkW-1-8*l -: 8]);
      if (back != chunk[ChunkW-1-8*l -: 8]) chk_fail = 1'b1;
    end
  end

  // Sticky error, cleared only by reset.
  always_comb begin
    err_d = err_q | ((state_q == StBusy) & chk_fail);
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // FSM next state, capture of the input word and per-beat result writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    inv_d   = inv_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          src_d   = bus.in_data;
          inv_d   = bus.in_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned c = 0; c < BEATS; c++) begin
          if (cnt_q == CntW'(c)) data_d[DataW-1-c*ChunkW -: ChunkW] = lane_sub;
        end
        if (cnt_q == CntW'(BEATS - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      inv_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      inv_q   <= inv_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Directed bench for subbytes_seq: a LANES=4 instance for latency, partial
// writes, backpressure and reset, plus a LANES=16 instance for single-beat use.
`timescale 1ns/1ps
module tb_subbytes_seq;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  localparam logic [127:0] Plain = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Subst = 128'h638293c31bfc33f5c4eeacea4bc12816;

  subbytes_seq_if #(.NUM_BYTES(16)) bus4 ();
  subbytes_seq_if #(.NUM_BYTES(16)) bus16 ();

  subbytes_seq #(.NUM_BYTES(16), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  subbytes_seq #(.NUM_BYTES(16), .LANES(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] d, input logic inv);
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    bus4.in_inv   = inv;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_inv = 1'b0;  bus4.in_data = '0;  bus4.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_inv = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("reset in_ready", 128'(bus4.in_ready), 128'd1);
    check_eq("reset out_valid", 128'(bus4.out_valid), 128'd0);
    check_eq("reset out_data", bus4.out_data, 128'd0);
    check_eq("reset err", 128'(bus4.err), 128'd0);

    // Partial writes land chunk by chunk, then reset mid-BUSY.
    accept(Plain, 1'b0);
    check_eq("busy in_ready", 128'(bus4.in_ready), 128'd0);
    tick();
    check_eq("beat0 data", bus4.out_data, 128'h638293c3000000000000000000000000);
    tick();
    check_eq("beat1 data", bus4.out_data, 128'h638293c31bfc33f50000000000000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst in_ready", 128'(bus4.in_ready), 128'd1);
    check_eq("midrst out_valid", 128'(bus4.out_valid), 128'd0);
    check_eq("midrst out_data", bus4.out_data, 128'd0);

    // Forward word after reset: 4-cycle latency.
    accept(Plain, 1'b0);
    check_eq("fwd early valid", 128'(bus4.out_valid), 128'd0);
    wait_done(lat);
    check_eq("fwd latency", 128'(lat), 128'd4);
    check_eq("fwd data", bus4.out_data, Subst);
    handshake();
    check_eq("post hs out_valid", 128'(bus4.out_valid), 128'd0);
    check_eq("post hs in_ready", 128'(bus4.in_ready), 128'd1);

    // Inverse round trip; untouched bytes keep the previous result.
    accept(Subst, 1'b1);
    tick();
    check_eq("inv beat0 data", bus4.out_data, 128'h001122331bfc33f5c4eeacea4bc12816);
    wait_done(lat);
    check_eq("inv latency", 128'(lat), 128'd3);
    check_eq("inv data", bus4.out_data, Plain);
    handshake();

    // Backpressure: result held, a pending word waits for IDLE.
    accept(Plain, 1'b0);
    wait_done(lat);
    bus4.in_valid = 1'b1;
    bus4.in_data  = Subst;
    bus4.in_inv   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp out_data", bus4.out_data, Subst);
      check_eq("bp in_ready", 128'(bus4.in_ready), 128'd0);
      check_eq("bp out_valid", 128'(bus4.out_valid), 128'd1);
    end
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check_eq("bp release out_valid", 128'(bus4.out_valid), 128'd0);
    check_eq("bp release in_ready", 128'(bus4.in_ready), 128'd1);
    tick();
    bus4.in_valid = 1'b0;
    check_eq("bp second accepted", 128'(bus4.in_ready), 128'd0);
    wait_done(lat);
    check_eq("bp second latency", 128'(lat), 128'd4);
    check_eq("bp second data", bus4.out_data, Plain);
    handshake();

    // Single-beat instance.
    bus16.in_valid = 1'b1;
    bus16.in_data  = '0;
    bus16.in_inv   = 1'b0;
    tick();
    bus16.in_valid = 1'b0;
    check_eq("l16 fwd early valid", 128'(bus16.out_valid), 128'd0);
    tick();
    check_eq("l16 fwd valid", 128'(bus16.out_valid), 128'd1);
    check_eq("l16 fwd data", bus16.out_data, {16{8'h63}});
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    bus16.in_valid = 1'b1;
    bus16.in_inv   = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    check_eq("l16 inv valid", 128'(bus16.out_valid), 128'd1);
    check_eq("l16 inv data", bus16.out_data, {16{8'h52}});
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;

`ifdef SUBBYTES_SELFCHECK_EN
    // Corrupt lane 0 of the forward lookups of an all-zero word.
    accept(128'd0, 1'b0);
    force dut.lane_sub = 32'h62636363;
    wait_done(lat);
    release dut.lane_sub;
    check_eq("sc err set", 128'(bus4.err), 128'd1);
    handshake();
    accept(Plain, 1'b0);
    wait_done(lat);
    handshake();
    check_eq("sc err sticky", 128'(bus4.err), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("sc err cleared", 128'(bus4.err), 128'd0);
    for (int i = 0; i < 1000; i++) begin
      accept({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_done(lat);
      handshake();
    end
    check_eq("sc random err", 128'(bus4.err), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
